// File: rtl/pulse_period_monitor_pkg.sv
// pulse_period_monitor_pkg: shared FSM encoding and arithmetic helper for the pulse period monitor
package pulse_period_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEEK = 2'd1,
    HIGH = 2'd2,
    LOW  = 2'd3
  } state_t;

  function automatic logic [31:0] abs_diff(input logic [31:0] a, input logic [31:0] b);
    return (a > b) ? a - b : b - a;
  endfunction

endpackage

// File: rtl/pulse_period_monitor_sync_edge_detect.sv
// sync_edge_detect: multi-flop synchronizer for an asynchronous input with rise/fall detection
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic s,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sr;
  logic s_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sr  <= '0;
      s_d <= 1'b0;
    end else begin
      sr  <= {sr[SYNC_STAGES-2:0], d};
      s_d <= sr[SYNC_STAGES-1];
    end
  end

  assign s    = sr[SYNC_STAGES-1];
  assign rise = s & ~s_d;
  assign fall = ~s & s_d;

endmodule

// File: rtl/pulse_period_monitor.sv
// pulse_period_monitor: measures high/low time and period of an asynchronous pulse train,
// flags period errors against an expected period and a stalled input.
module pulse_period_monitor
  import pulse_period_monitor_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 60000,
  parameter int EXP_PERIOD  = 40,
  parameter int TOL         = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             pulse_in,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] low_cnt,
  output logic [CNT_W:0]   period,
  output logic             valid,
  output logic             period_err,
  output logic             stall
);

  localparam logic [CNT_W-1:0] TO = CNT_W'(TIMEOUT);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] h_lat;
  logic             s;
  logic             rise;
  logic             fall;
  logic [CNT_W:0]   p_next;
  logic             err_next;
  logic             timed_out;

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clock  (clock),
    .reset_n(reset_n),
    .d      (pulse_in),
    .s      (s),
    .rise   (rise),
    .fall   (fall)
  );

  assign p_next    = {1'b0, h_lat} + {1'b0, cnt};
  assign err_next  = abs_diff(32'(p_next), 32'(EXP_PERIOD)) > 32'(TOL);
  assign timed_out = cnt >= TO;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      h_lat      <= '0;
      high_cnt   <= '0;
      low_cnt    <= '0;
      period     <= '0;
      valid      <= 1'b0;
      period_err <= 1'b0;
      stall      <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (!enable) begin
        state <= IDLE;
        cnt   <= '0;
        stall <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            state <= SEEK;
            cnt   <= '0;
          end
          SEEK: begin
            if (rise) begin
              state <= HIGH;
              cnt   <= CNT_W'(1);
            end else if (timed_out) begin
              stall <= 1'b1;
              cnt   <= '0;
            end else
              cnt <= cnt + 1'b1;
          end
          HIGH: begin
            if (fall) begin
              h_lat <= cnt;
              cnt   <= CNT_W'(1);
              state <= LOW;
            end else if (timed_out) begin
              stall <= 1'b1;
              cnt   <= '0;
              state <= SEEK;
            end else
              cnt <= cnt + 1'b1;
          end
          LOW: begin
            if (rise) begin
              high_cnt   <= h_lat;
              low_cnt    <= cnt;
              period     <= p_next;
              period_err <= err_next;
              valid      <= 1'b1;
              cnt        <= CNT_W'(1);
              state      <= HIGH;
            end else if (timed_out) begin
              stall <= 1'b1;
              cnt   <= '0;
              state <= SEEK;
            end else
              cnt <= cnt + 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pulse_period_monitor.sv
// tb_pulse_period_monitor: directed self-checking bench for pulse_period_monitor
module tb_pulse_period_monitor;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        pulse_in;
  logic [15:0] high_cnt;
  logic [15:0] low_cnt;
  logic [16:0] period;
  logic        valid;
  logic        period_err;
  logic        stall;

  int checks   = 0;
  int failures = 0;
  int vcnt     = 0;
  int base;

  pulse_period_monitor #(
    .CNT_W(16), .SYNC_STAGES(2), .TIMEOUT(100), .EXP_PERIOD(40), .TOL(1)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .enable    (enable),
    .pulse_in  (pulse_in),
    .high_cnt  (high_cnt),
    .low_cnt   (low_cnt),
    .period    (period),
    .valid     (valid),
    .period_err(period_err),
    .stall     (stall)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (valid) vcnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int k);
    repeat (k) @(posedge clock);
    #1;
  endtask

  task automatic drive(input int h, input int l, input int n);
    repeat (n) begin
      pulse_in = 1'b1;
      cyc(h);
      pulse_in = 1'b0;
      cyc(l);
    end
  endtask

  task automatic restart();
    enable   = 1'b0;
    pulse_in = 1'b0;
    cyc(6);
    enable = 1'b1;
    cyc(4);
    base = vcnt;
  endtask

  task automatic chk_result(input string tag, input int nv, input int h, input int l,
                            input int p, input logic e);
    chk({tag, "_nvalid"}, 32'(vcnt - base), 32'(nv));
    chk({tag, "_high"}, 32'(high_cnt), 32'(h));
    chk({tag, "_low"}, 32'(low_cnt), 32'(l));
    chk({tag, "_period"}, 32'(period), 32'(p));
    chk({tag, "_err"}, 32'(period_err), 32'(e));
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, {high_cnt, low_cnt[15:0]}, 32'd0);
    chk({tag, "_flags"}, {12'd0, period, valid, period_err, stall}, 32'd0);
  endtask

  task automatic duty(input string tag, input int h, input int l, input int n, input logic e);
    restart();
    drive(h, l, n);
    pulse_in = 1'b1;
    cyc(6);
    chk_result(tag, n, h, l, h + l, e);
  endtask

  initial begin
    reset_n  = 1'b0;
    enable   = 1'b1;
    pulse_in = 1'b0;
    cyc(2);
    pulse_in = 1'b1;
    cyc(2);
    chk_zero("reset");
    pulse_in = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    cyc(1);
    duty("sq20", 20, 20, 3, 1'b0);
    duty("d30_10", 30, 10, 2, 1'b0);
    duty("d30_13", 30, 13, 2, 1'b1);
    duty("p41", 20, 21, 2, 1'b0);
    duty("p42", 20, 22, 2, 1'b1);
    duty("p39", 19, 20, 2, 1'b0);
    duty("p38", 19, 19, 2, 1'b1);
    restart();
    drive(20, 20, 1);
    pulse_in = 1'b1;
    cyc(100);
    chk("to_pre_stall", 32'(stall), 32'd0);
    cyc(10);
    chk("to_stall", 32'(stall), 32'd1);
    cyc(40);
    chk("to_no_valid", 32'(vcnt - base), 32'd1);
    pulse_in = 1'b0;
    cyc(20);
    drive(20, 20, 2);
    pulse_in = 1'b1;
    cyc(6);
    chk_result("to_resume", 3, 20, 20, 40, 1'b0);
    chk("to_sticky", 32'(stall), 32'd1);
    cyc(4);
    #3;
    reset_n = 1'b0;
    #1;
    chk_zero("rst_mid");
    pulse_in = 1'b0;
    cyc(3);
    @(negedge clock);
    reset_n = 1'b1;
    cyc(1);
    base = vcnt;
    cyc(20);
    drive(20, 20, 1);
    chk("rst_no_valid", 32'(vcnt - base), 32'd0);
    pulse_in = 1'b1;
    cyc(6);
    chk_result("rst_after", 1, 20, 20, 40, 1'b0);
    restart();
    drive(25, 15, 2);
    pulse_in = 1'b1;
    cyc(110);
    chk("en_stall", 32'(stall), 32'd1);
    pulse_in = 1'b0;
    cyc(20);
    pulse_in = 1'b1;
    cyc(20);
    pulse_in = 1'b0;
    cyc(8);
    enable = 1'b0;
    cyc(5);
    chk("en_stall_clr", 32'(stall), 32'd0);
    chk_result("en_hold", 2, 25, 15, 40, 1'b0);
    enable = 1'b1;
    cyc(10);
    drive(20, 20, 1);
    pulse_in = 1'b1;
    cyc(6);
    chk_result("en_after", 3, 20, 20, 40, 1'b0);
    duty("min", 1, 1, 4, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
